// File: rtl/jt51_kon_wr_if.sv
// jt51 key-on write front end bus.
// Groups the MMR write side, the slot position and the key-on outputs.
interface jt51_kon_wr_if;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] cur_op;
  logic [2:0] cur_ch;
  logic [3:0] keyon_op;
  logic [2:0] keyon_ch;
  logic       up_keyon;
  logic       csm;
  logic       busy;
  logic       wr_drop;

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  cur_op, cur_ch,
    output keyon_op, keyon_ch,
    output up_keyon, csm, busy, wr_drop
  );

  modport master (
    output wr_en, wr_addr, wr_data,
    output cur_op, cur_ch,
    input  keyon_op, keyon_ch,
    input  up_keyon, csm, busy, wr_drop
  );
endinterface

// File: rtl/jt51_kon_wr.sv
// jt51 key-on write front end: queues 0x08 writes and
// holds each one until all four slots of its channel pass.
module jt51_kon_wr #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] KON_ADDR   = 8'h08,
  parameter logic [7:0] CSM_ADDR   = 8'h14
) (
  input logic          rst,
  input logic          clk,
  input logic          clk_en,
  jt51_kon_wr_if.slave bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t        state;
  logic [6:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [1:0]    match;
  logic [3:0]    op_q;
  logic [2:0]    ch_q;
  logic          up_q;
  logic          csm_q;
  logic          drop_q;

  logic kon_wr;
  logic csm_wr;
  logic full;
  logic pop;
  logic push;
  logic hit;

  // The sweep only tracks channels; operator is informational.
  logic unused_cur_op;
  assign unused_cur_op = ^bus.cur_op;

  assign kon_wr = bus.wr_en && (bus.wr_addr == KON_ADDR);
  assign csm_wr = bus.wr_en && (bus.wr_addr == CSM_ADDR);
  assign full   = (count == CW'(FIFO_DEPTH));
  assign pop    = (state == IDLE) && (count != '0);
  assign push   = kon_wr && (!full || pop);
  assign hit    = (bus.cur_ch == ch_q);

  assign bus.keyon_op = op_q;
  assign bus.keyon_ch = ch_q;
  assign bus.up_keyon = up_q;
  assign bus.csm      = csm_q;
  assign bus.busy     = full;
  assign bus.wr_drop  = drop_q;

  // Queue storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (clk_en && push)
      mem[wr_ptr] <= {bus.wr_data[6:3], bus.wr_data[2:0]};
  end

  // Pointers and occupancy; a full queue accepts only with a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clk_en) begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // CSM bit capture and drop pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csm_q  <= 1'b0;
      drop_q <= 1'b0;
    end else if (clk_en) begin
      if (csm_wr)
        csm_q <= bus.wr_data[7];
      drop_q <= kon_wr && full && !pop;
    end
  end

  // Sweep control: pop in IDLE, hold until 4 channel matches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
      ch_q  <= '0;
      up_q  <= 1'b0;
      match <= '0;
    end else if (clk_en) begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            {op_q, ch_q} <= mem[rd_ptr];
            match        <= '0;
            up_q         <= 1'b1;
            state        <= SWEEP;
          end
        end
        SWEEP: begin
          if (hit) begin
            match <= match + 2'd1;
            if (match == 2'd3) begin
              up_q  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          up_q  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jt51_kon_wr.sv
// Self-checking bench for jt51_kon_wr.
// Queue-based reference model plus directed and random scenarios.
module tb_jt51_kon_wr;

  localparam int DEPTH = 4;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic clk_en = 1'b0;

  jt51_kon_wr_if bus();

  jt51_kon_wr #(
    .FIFO_DEPTH(DEPTH),
    .KON_ADDR  (8'h08),
    .CSM_ADDR  (8'h14)
  ) dut (
    .rst   (rst),
    .clk   (clk),
    .clk_en(clk_en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [4:0] slot = '0;

  // Reference model: pending writes, active sweep, seen matches.
  logic [6:0] m_q[$];
  bit         m_active;
  logic [3:0] m_op;
  logic [2:0] m_ch;
  int         m_seen;
  bit         m_csm;
  bit         m_drop;

  task automatic model_reset();
    m_q.delete();
    m_active = 0;
    m_op     = '0;
    m_ch     = '0;
    m_seen   = 0;
    m_csm    = 0;
    m_drop   = 0;
  endtask

  task automatic model_step(input bit we, input logic [7:0] a,
                            input logic [7:0] d, input logic [2:0] ch);
    bit         pop_now;
    logic [6:0] e;
    pop_now = !m_active && (m_q.size() > 0);
    m_drop  = 0;
    if (m_active) begin
      if (ch == m_ch) begin
        m_seen++;
        if (m_seen == 4) m_active = 0;
      end
    end else if (pop_now) begin
      e        = m_q.pop_front();
      m_op     = e[6:3];
      m_ch     = e[2:0];
      m_active = 1;
      m_seen   = 0;
    end
    if (we && a == 8'h08) begin
      if (m_q.size() < DEPTH) m_q.push_back({d[6:3], d[2:0]});
      else m_drop = 1;
    end
    if (we && a == 8'h14) m_csm = d[7];
  endtask

  task automatic tick(input bit ce, input bit we,
                      input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    clk_en      = ce;
    bus.wr_en   = we;
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.cur_ch  = slot[2:0];
    bus.cur_op  = slot[4:3];
    @(posedge clk);
    if (ce) begin
      model_step(we, a, d, slot[2:0]);
      slot = slot + 5'd1;
    end
    #1;
  endtask

  task automatic idle();
    tick(1'b1, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.up_keyon !== 1'b0) begin
      failures++; $display("FAIL reset_up got %0b want 0", bus.up_keyon);
    end
    checks++;
    if (bus.keyon_op !== 4'h0) begin
      failures++; $display("FAIL reset_op got %0h want 0", bus.keyon_op);
    end
    checks++;
    if (bus.keyon_ch !== 3'd0) begin
      failures++; $display("FAIL reset_ch got %0d want 0", bus.keyon_ch);
    end
    checks++;
    if (bus.csm !== 1'b0) begin
      failures++; $display("FAIL reset_csm got %0b want 0", bus.csm);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got %0b want 0", bus.busy);
    end
    checks++;
    if (bus.wr_drop !== 1'b0) begin
      failures++; $display("FAIL reset_drop got %0b want 0", bus.wr_drop);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    int hi;
    tick(1'b1, 1'b1, 8'h08, 8'h7A);
    checks++;
    if (bus.up_keyon !== 1'b0) begin
      failures++; $display("FAIL single_lat1 got %0b want 0", bus.up_keyon);
    end
    idle();
    checks++;
    if (bus.up_keyon !== 1'b1) begin
      failures++; $display("FAIL single_up got %0b want 1", bus.up_keyon);
    end
    checks++;
    if (bus.keyon_op !== 4'hF) begin
      failures++; $display("FAIL single_op got %0h want f", bus.keyon_op);
    end
    checks++;
    if (bus.keyon_ch !== 3'd2) begin
      failures++; $display("FAIL single_ch got %0d want 2", bus.keyon_ch);
    end
    hi = 1;
    for (int i = 0; i < 40 && bus.up_keyon; i++) begin
      idle();
      checks++;
      if (bus.up_keyon !== m_active) begin
        failures++;
        $display("FAIL single_sweep got %0b want %0b", bus.up_keyon, m_active);
      end
      if (bus.up_keyon) hi++;
    end
    checks++;
    if (bus.up_keyon !== 1'b0 || hi > 32 || hi < 4) begin
      failures++;
      $display("FAIL single_len up=%0b high=%0d want 0 and 4..32",
               bus.up_keyon, hi);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq[$];
    logic [7:0] d;
    bit prev;
    int zeros;
    tick(1'b1, 1'b1, 8'h08, 8'h7F);
    idle();
    for (int i = 0; i < 5; i++) begin
      d = {1'b0, 4'($urandom_range(0, 15)), 3'(i)};
      tick(1'b1, 1'b1, 8'h08, d);
      if (i == 3) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          failures++; $display("FAIL b2b_busy got %0b want 1", bus.busy);
        end
      end
    end
    checks++;
    if (bus.wr_drop !== 1'b1) begin
      failures++; $display("FAIL b2b_drop got %0b want 1", bus.wr_drop);
    end
    idle();
    checks++;
    if (bus.wr_drop !== 1'b0) begin
      failures++; $display("FAIL b2b_drop_pulse got %0b want 0", bus.wr_drop);
    end
    prev  = bus.up_keyon;
    zeros = 0;
    for (int i = 0; i < 300; i++) begin
      idle();
      checks++;
      if (bus.up_keyon !== m_active || bus.busy !== (m_q.size() == DEPTH)) begin
        failures++;
        $display("FAIL b2b_track up=%0b/%0b busy=%0b/%0b",
                 bus.up_keyon, m_active, bus.busy, m_q.size() == DEPTH);
      end
      if (bus.up_keyon && !prev) begin
        seq.push_back(bus.keyon_ch);
        checks++;
        if (zeros != 1) begin
          failures++; $display("FAIL b2b_gap got %0d want 1", zeros);
        end
      end
      if (!bus.up_keyon) zeros++;
      else zeros = 0;
      prev = bus.up_keyon;
      if (seq.size() == 4 && !bus.up_keyon) break;
    end
    checks++;
    if (seq.size() != 4 || bus.up_keyon !== 1'b0) begin
      failures++;
      $display("FAIL b2b_count got %0d sweeps want 4", seq.size());
    end
    for (int i = 0; i < seq.size(); i++) begin
      checks++;
      if (seq[i] !== 3'(i)) begin
        failures++; $display("FAIL b2b_order got %0d want %0d", seq[i], i);
      end
    end
  endtask

  task automatic test_csm();
    tick(1'b1, 1'b1, 8'h14, 8'h80);
    checks++;
    if (bus.csm !== 1'b1) begin
      failures++; $display("FAIL csm_set got %0b want 1", bus.csm);
    end
    tick(1'b1, 1'b1, 8'h14, 8'h00);
    checks++;
    if (bus.csm !== 1'b0) begin
      failures++; $display("FAIL csm_clr got %0b want 0", bus.csm);
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      checks++;
      if (bus.up_keyon !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL csm_noq up=%0b busy=%0b want 0 0",
                 bus.up_keyon, bus.busy);
      end
    end
  endtask

  task automatic test_keyoff();
    tick(1'b1, 1'b1, 8'h08, 8'h05);
    idle();
    checks++;
    if (bus.up_keyon !== 1'b1 || bus.keyon_op !== 4'h0 ||
        bus.keyon_ch !== 3'd5) begin
      failures++;
      $display("FAIL keyoff_start up=%0b op=%0h ch=%0d want 1 0 5",
               bus.up_keyon, bus.keyon_op, bus.keyon_ch);
    end
    for (int i = 0; i < 40 && bus.up_keyon; i++) begin
      idle();
      checks++;
      if (bus.up_keyon !== m_active || bus.keyon_ch !== 3'd5) begin
        failures++;
        $display("FAIL keyoff_sweep up=%0b/%0b ch=%0d",
                 bus.up_keyon, m_active, bus.keyon_ch);
      end
    end
    checks++;
    if (bus.up_keyon !== 1'b0) begin
      failures++; $display("FAIL keyoff_end got %0b want 0", bus.up_keyon);
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b1, 8'h08, 8'h79);
    tick(1'b1, 1'b1, 8'h08, 8'h52);
    tick(1'b1, 1'b1, 8'h08, 8'h63);
    idle();
    checks++;
    if (bus.up_keyon !== 1'b1) begin
      failures++; $display("FAIL rmid_pre got %0b want 1", bus.up_keyon);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.up_keyon, bus.keyon_op, bus.keyon_ch, bus.csm,
         bus.busy, bus.wr_drop} !== 11'd0) begin
      failures++;
      $display("FAIL rmid_async up=%0b op=%0h ch=%0d want 0",
               bus.up_keyon, bus.keyon_op, bus.keyon_ch);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 40; i++) begin
      idle();
      checks++;
      if (bus.up_keyon !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL rmid_after up=%0b busy=%0b want 0 0",
                 bus.up_keyon, bus.busy);
      end
    end
  endtask

  task automatic test_clk_en_gate();
    tick(1'b0, 1'b1, 8'h08, 8'h33);
    tick(1'b0, 1'b1, 8'h08, 8'h44);
    checks++;
    if (bus.wr_drop !== 1'b0) begin
      failures++; $display("FAIL gate_drop got %0b want 0", bus.wr_drop);
    end
    for (int i = 0; i < 5; i++) begin
      idle();
      checks++;
      if (bus.up_keyon !== 1'b0 || bus.busy !== 1'b0 ||
          bus.wr_drop !== 1'b0) begin
        failures++;
        $display("FAIL gate_idle up=%0b busy=%0b drop=%0b want 0 0 0",
                 bus.up_keyon, bus.busy, bus.wr_drop);
      end
    end
  endtask

  task automatic test_random();
    bit         ce;
    bit         we;
    logic [7:0] a;
    logic [7:0] d;
    int         sel;
    for (int i = 0; i < 600; i++) begin
      ce  = ($urandom_range(0, 7) != 0);
      we  = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 9);
      if (sel < 7) a = 8'h08;
      else if (sel < 9) a = 8'h14;
      else a = 8'($urandom_range(0, 255));
      d = 8'($urandom);
      tick(ce, we, a, d);
      checks++;
      if (bus.up_keyon !== m_active || bus.keyon_op !== m_op ||
          bus.keyon_ch !== m_ch || bus.csm !== m_csm ||
          bus.busy !== (m_q.size() == DEPTH) || bus.wr_drop !== m_drop) begin
        failures++;
        $display("FAIL rand_%0d got up=%0b op=%0h ch=%0d csm=%0b busy=%0b drop=%0b want %0b %0h %0d %0b %0b %0b",
                 i, bus.up_keyon, bus.keyon_op, bus.keyon_ch, bus.csm,
                 bus.busy, bus.wr_drop, m_active, m_op, m_ch, m_csm,
                 m_q.size() == DEPTH, m_drop);
      end
    end
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.cur_op  = '0;
    bus.cur_ch  = '0;
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_csm();
    test_keyoff();
    test_reset_mid();
    test_clk_en_gate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jt51_kon_wr.md
Name: jt51_kon_wr

Overview:
Write-side front end for the key-on slot logic. It captures CPU writes to the key-on register (0x08) and the CSM control bit (register 0x14 bit 7). Captured writes are queued in a small FIFO. Each write is presented as keyon_op / keyon_ch / up_keyon and held until every operator slot of the target channel has passed through the 32-slot pipeline. The block sits between the MMR write decoder and the key-on shift-register block; it drives that block's keyon_op, keyon_ch, up_keyon and csm inputs.

Parameters:
FIFO_DEPTH, 4, number of pending key-on writes held (power of two, 2..16)
KON_ADDR, 8'h08, register address decoded as key-on
CSM_ADDR, 8'h14, register address whose bit 7 is CSM

Ports:
rst  input  1  asynchronous reset, active high
clk  input  1  system clock
clk_en  input  1  clock enable; all state advances only when high
wr_en  input  1  register write strobe, valid for one clk_en cycle
wr_addr  input  8  register address
wr_data  input  8  register data
cur_op  input  2  operator of the slot currently in stage II
cur_ch  input  3  channel of the slot currently in stage II
keyon_op  output  4  operator mask {C2,M2,C1,M1} = wr_data[6:3]
keyon_ch  output  3  target channel = wr_data[2:0]
up_keyon  output  1  key-on update active
csm  output  1  CSM mode bit
busy  output  1  FIFO full; a further write is dropped unless a pop happens in the same cycle
wr_drop  output  1  one-clk_en pulse when a key-on write was discarded

Behaviour:
- Reset (async, rst=1): FIFO empty; state IDLE; keyon_op=0, keyon_ch=0, up_keyon=0, csm=0, busy=0, wr_drop=0; match counter=0. Reset mid-sweep aborts the sweep immediately and discards queued entries.
- Decode, on clk_en:
  - wr_en && wr_addr==KON_ADDR pushes {wr_data[6:3], wr_data[2:0]}. wr_data[7] is ignored.
  - wr_en && wr_addr==CSM_ADDR sets csm <= wr_data[7] on the next clk_en edge. It never enters the FIFO.
  - Other addresses are ignored.
- FIFO: circular buffer with a count register of width clog2(FIFO_DEPTH)+1.
  - busy = (count==FIFO_DEPTH).
  - A push while full is accepted only if a pop occurs in the same clk_en cycle. Otherwise the push is dropped and wr_drop=1 for that clk_en cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - Writes are preserved and issued in arrival order; identical writes are not merged.
- State machine (advances on clk_en only):
  - IDLE: up_keyon=0. If count>0: pop the head into keyon_op/keyon_ch, clear the match counter, go to SWEEP. The pop is visible one clk_en after entry into IDLE with a non-empty FIFO.
  - SWEEP: up_keyon=1.
    - Each clk_en cycle with cur_ch==keyon_ch increments the match counter (0..3).
    - On the cycle in which the 4th match is seen: go to IDLE, and up_keyon=0 from the next clk_en.
    - keyon_op/keyon_ch are held stable for the entire SWEEP.
  - Back-to-back: when the FIFO is non-empty on return to IDLE, the next entry is popped in that IDLE cycle. This gives exactly one clk_en cycle with up_keyon=0 between sweeps.
- Latency:
  - Push to up_keyon rising: 2 clk_en cycles when IDLE and empty.
  - SWEEP length: at most 32 clk_en cycles, at least 4 when slots match consecutively.
- A push and a pop in the same cycle leave count unchanged.
- Writes arriving while clk_en=0 are ignored.
- keyon_op=0 is a valid write (key-off); it is queued and swept like any other.

Test Plan:
- Reset, then write 0x08=0x7A (op=4'hF, ch=2) while IDLE → keyon_op=4'hF, keyon_ch=3'd2, up_keyon=1 two clk_en later. up_keyon falls one clk_en after the 4th slot with cur_ch==2. Total high ≤32 clk_en.
- Five back-to-back 0x08 writes (ch 0..4) with FIFO_DEPTH=4 while sweep 0 is active → writes 0,1,2,3 accepted, 5th dropped with wr_drop=1. busy=1 while full. Sweeps issue ch 0,1,2,3 in order, with exactly one up_keyon=0 cycle between them.
- Write 0x14=0x80, then 0x14=0x00 → csm=1 then csm=0, one clk_en after each write. FIFO count stays 0 and up_keyon never rises.
- Write 0x08=0x05 (op=0, ch=5) → sweep runs for channel 5 with keyon_op=0. up_keyon pulse lasts until 4 ch-5 slots have passed.
- Assert rst for 1 clk mid-SWEEP with 2 entries queued → all outputs 0 asynchronously. After release no sweep starts without new writes.
- Pulse wr_en with clk_en=0 → no push; count stays 0 and wr_drop stays 0.
